seg_scan_decoder: RTL and testbench
===================================

Name: seg_scan_decoder

Overview:
- Receive-side counterpart to the team's multiplexed 7-segment display drivers, such as the 0-99 up/down counter display.
- Samples the active-low anode and segment bus, waits for each digit strobe to settle, then decodes the segment pattern back to a digit code.
- After every scanned digit has been captured, it publishes a coherent frame plus the binary value of the lower two digits.
- Used for board-level loopback self-test and as a bench monitor for display-driving blocks.

Parameters:
- NUM_DIGITS, 4, number of scanned digit positions (anode bits 0..NUM_DIGITS-1); range 2..8.
- SETTLE, 4, consecutive cycles the {an, seg} bus must hold unchanged before a digit is captured; at least 2.
- TO_W, 20, width of the frame timeout counter; `stale` asserts after 2^TO_W cycles without a completed frame.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- an  in  8  anode strobes, active low.
- seg  in  7  segments {g,f,e,d,c,b,a}, active low.
- dp  in  1  decimal point, active low; captured but not decoded.
- digits  out  4*NUM_DIGITS  latched digit codes; digit i occupies bits [4i+3:4i].
- dps  out  NUM_DIGITS  latched dp bits, active high (lit = 1).
- value  out  7  binary value digit1*10 + digit0, range 0..99.
- value_valid  out  1  high when both digit0 and digit1 of the last frame are 0..9.
- frame_valid  out  1  one-cycle pulse when digits/dps/value update.
- seg_err  out  1  one-cycle pulse on capture of an undecodable pattern.
- an_err  out  1  one-cycle pulse when more than one anode is low.
- stale  out  1  level; no frame completed within the timeout.

Behaviour:
- Reset state: digits=0, dps=0, value=0, value_valid=0, frame_valid=0, seg_err=0, an_err=0, stale=0. The internal capture mask, stability counter and timeout counter are cleared; the FSM enters WAIT.
- Registered inputs:
  - an, seg and dp are registered once on entry.
  - All decisions use the registered copy and its previous-cycle copy.
- FSM states:
  - WAIT: stab_cnt increments each cycle the registered {an, seg, dp} equals the previous cycle's value. Any change resets stab_cnt to 0. When stab_cnt reaches SETTLE-1 and an is a valid single-low strobe with index < NUM_DIGITS, the digit is captured and the FSM moves to HELD.
  - HELD: no further capture. Any change of an returns the FSM to WAIT with stab_cnt=0. A change of seg alone while an is held also returns to WAIT, and the digit is re-captured once it is stable again; the newest capture overwrites.
- Anodes that are not captured:
  - an = 8'hFF (blanking) or a low bit at index >= NUM_DIGITS: no capture, no error.
  - Two or more low bits: an_err pulses on the first cycle of that pattern, and no capture occurs.
- Decode table (seg -> code):
  - 1000000 -> 0, 1111001 -> 1, 0100100 -> 2, 0110000 -> 3, 0011001 -> 4.
  - 0010010 -> 5, 0000010 -> 6, 1111000 -> 7, 0000000 -> 8, 0010000 -> 9.
  - 0111111 (dash) -> 4'hA; 1111111 (blank) -> 4'hB.
  - Any other pattern -> 4'hE, and seg_err pulses in the capture cycle.
- Capture: the code and ~dp are written to a shadow slot for that index, and the corresponding mask bit is set.
- Frame completion:
  - The cycle after the mask becomes all ones, the shadow is copied to digits/dps and frame_valid pulses for exactly one cycle.
  - value and value_valid update in that same cycle; the mask clears.
  - Latency from the first stable cycle of the final digit to frame_valid: SETTLE+1 cycles.
- value arithmetic:
  - value = shadow digit1*10 + shadow digit0, computed in 7 bits.
  - If either digit is > 9, value=0 and value_valid=0.
- Timeout:
  - to_cnt increments each cycle and clears on frame_valid.
  - At all-ones it saturates and stale=1; stale clears on the next frame_valid.
- Reset mid-frame: partial captures are discarded, and outputs return to their reset values in the same clock edge.

Test Plan:
- Scan digit0=7, digit1=4, digits2/3=dash; 1000-cycle dwell each; dps all off -> frame_valid pulses once per full scan, digits=16'hAA47, value=47, value_valid=1, dps=0.
- Dwell of SETTLE-1 cycles on digit3 only, then advance -> no capture of digit3, no frame_valid, mask retains bits 0-2.
- an=8'b11111100 for 5 cycles in the middle of a scan -> an_err pulse in exactly one cycle, no capture; scanning resumes and the frame completes on the next full pass.
- seg=0101010 on digit1 -> seg_err pulse, digit1 code E, value=0, value_valid=0.
- Count sequence 99 -> up -> 00 driven across frames -> consecutive frames report value 99 then 0; a glitchy 1-cycle seg change mid-dwell is re-captured correctly.
- With TO_W=8, hold an=8'hFF for 300 cycles -> stale=1 at cycle 256 after the last frame; assert reset in the middle of a scan -> all outputs 0 on the next edge and the mask is cleared.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// Receive side of a multiplexed active-low 7-segment bus. Each settled digit strobe is
// decoded into a shadow slot; a full set of slots is published as one coherent frame.

module seg_scan_slot (
    input  logic       clock,
    input  logic       reset,
    input  logic       wr,
    input  logic       clr,
    input  logic [3:0] code_in,
    input  logic       dp_in,
    output logic [3:0] code,
    output logic       dp_lit,
    output logic       hit
);
    always_ff @(posedge clock) begin
        if (reset) begin
            code   <= 4'h0;
            dp_lit <= 1'b0;
            hit    <= 1'b0;
        end else if (wr) begin
            code   <= code_in;
            dp_lit <= dp_in;
            hit    <= 1'b1;
        end else if (clr) begin
            hit    <= 1'b0;
        end
    end
endmodule

module seg_scan_decoder #(
    parameter int NUM_DIGITS = 4,
    parameter int SETTLE     = 4,
    parameter int TO_W       = 20
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [7:0]              an,
    input  logic [6:0]              seg,
    input  logic                    dp,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   dps,
    output logic [6:0]              value,
    output logic                    value_valid,
    output logic                    frame_valid,
    output logic                    seg_err,
    output logic                    an_err,
    output logic                    stale
);
    localparam int SW = $clog2(SETTLE);
    localparam logic [7:0] DIG_MASK = 8'((1 << NUM_DIGITS) - 1);

    typedef enum logic {S_WAIT, S_HELD} state_t;
    typedef struct packed {
        logic [3:0] code;
        logic       dp_lit;
    } cap_t;

    logic [7:0] an_r, an_p;
    logic [6:0] seg_r, seg_p;
    logic       dp_r, dp_p;

    logic [7:0] an_low;
    logic       an_same, seg_same, bus_same;
    logic       one_low, multi_low, dig_ok, settled, capture, publish;
    logic [SW-1:0] stab_cnt;
    state_t     state, state_nx;
    cap_t       cap;

    logic [NUM_DIGITS-1:0][3:0] shadow, digits_q;
    logic [NUM_DIGITS-1:0]      shadow_dp, mask;
    logic [TO_W-1:0]            to_cnt;

    logic [3:0] d0, d1;
    logic       bcd_ok;
    logic [6:0] value_c;

    always_ff @(posedge clock) begin
        if (reset) begin
            an_r  <= 8'hFF;
            an_p  <= 8'hFF;
            seg_r <= 7'h7F;
            seg_p <= 7'h7F;
            dp_r  <= 1'b1;
            dp_p  <= 1'b1;
        end else begin
            an_r  <= an;
            an_p  <= an_r;
            seg_r <= seg;
            seg_p <= seg_r;
            dp_r  <= dp;
            dp_p  <= dp_r;
        end
    end

    assign an_same   = (an_r == an_p);
    assign seg_same  = (seg_r == seg_p);
    assign bus_same  = an_same && seg_same && (dp_r == dp_p);
    assign an_low    = ~an_r;
    assign multi_low = (an_low & (an_low - 8'd1)) != 8'd0;
    assign one_low   = (an_low != 8'd0) && !multi_low;
    assign dig_ok    = one_low && ((an_low & ~DIG_MASK) == 8'd0);
    // the increment that would take stab_cnt to SETTLE-1 is the capture point
    assign settled   = bus_same && (stab_cnt == SW'(SETTLE - 2));
    assign publish   = &mask;

    always_comb begin
        cap.dp_lit = ~dp_r;
        case (seg_r)
            7'b1000000: cap.code = 4'h0;
            7'b1111001: cap.code = 4'h1;
            7'b0100100: cap.code = 4'h2;
            7'b0110000: cap.code = 4'h3;
            7'b0011001: cap.code = 4'h4;
            7'b0010010: cap.code = 4'h5;
            7'b0000010: cap.code = 4'h6;
            7'b1111000: cap.code = 4'h7;
            7'b0000000: cap.code = 4'h8;
            7'b0010000: cap.code = 4'h9;
            7'b0111111: cap.code = 4'hA;
            7'b1111111: cap.code = 4'hB;
            default:    cap.code = 4'hE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= S_WAIT;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_WAIT: if (capture) state_nx = S_HELD;
            S_HELD: if (!an_same || !seg_same) state_nx = S_WAIT;
            default: state_nx = S_WAIT;
        endcase
    end

    always_comb begin
        capture = 1'b0;
        if (state == S_WAIT && settled && dig_ok) capture = 1'b1;
    end

    // held state parks the counter so a return to WAIT always restarts from zero
    always_ff @(posedge clock) begin
        if (reset || !bus_same || state == S_HELD) stab_cnt <= '0;
        else if (stab_cnt != SW'(SETTLE - 1))       stab_cnt <= stab_cnt + SW'(1);
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_slot
        seg_scan_slot u_slot (
            .clock   (clock),
            .reset   (reset),
            .wr      (capture && an_low[i]),
            .clr     (publish),
            .code_in (cap.code),
            .dp_in   (cap.dp_lit),
            .code    (shadow[i]),
            .dp_lit  (shadow_dp[i]),
            .hit     (mask[i])
        );
    end

    assign d0      = shadow[0];
    assign d1      = shadow[1];
    assign bcd_ok  = (d0 <= 4'd9) && (d1 <= 4'd9);
    assign value_c = bcd_ok ? (7'(d1) * 7'd10 + 7'(d0)) : 7'd0;

    always_ff @(posedge clock) begin
        if (reset) begin
            digits_q    <= '0;
            dps         <= '0;
            value       <= 7'd0;
            value_valid <= 1'b0;
            frame_valid <= 1'b0;
            seg_err     <= 1'b0;
            an_err      <= 1'b0;
            to_cnt      <= '0;
            stale       <= 1'b0;
        end else begin
            frame_valid <= publish;
            seg_err     <= capture && (cap.code == 4'hE);
            an_err      <= multi_low && !an_same;
            if (publish) begin
                digits_q    <= shadow;
                dps         <= shadow_dp;
                value       <= value_c;
                value_valid <= bcd_ok;
                to_cnt      <= '0;
                stale       <= 1'b0;
            end else if (to_cnt != '1) begin
                to_cnt <= to_cnt + TO_W'(1);
            end else begin
                stale <= 1'b1;
            end
        end
    end

    assign digits = digits_q;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Randomised and directed stimulus for seg_scan_decoder, checked every cycle against an
// event-level model built from run lengths of the pin bus.

module tb_seg_scan_decoder;
  localparam int ND = 4;
  localparam int ST = 4;
  localparam int TW = 8;
  localparam logic [6:0] PAT [12] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                      7'b0000000, 7'b0010000, 7'b0111111, 7'b1111111};

  logic clock = 1'b0;
  logic reset;
  logic [7:0] an;
  logic [6:0] seg;
  logic dp;
  logic [4*ND-1:0] digits;
  logic [ND-1:0] dps;
  logic [6:0] value;
  logic value_valid, frame_valid, seg_err, an_err, stale;

  seg_scan_decoder #(.NUM_DIGITS(ND), .SETTLE(ST), .TO_W(TW)) dut (
    .clock(clock), .reset(reset), .an(an), .seg(seg), .dp(dp),
    .digits(digits), .dps(dps), .value(value), .value_valid(value_valid),
    .frame_valid(frame_valid), .seg_err(seg_err), .an_err(an_err), .stale(stale)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // model state: expected outputs plus events scheduled for the next edge
  logic [3:0] m_code [ND];
  logic m_dp [ND];
  logic [ND-1:0] m_mask;
  logic [4*ND-1:0] e_digits;
  logic [ND-1:0] e_dps;
  logic [6:0] e_value;
  logic e_vv, e_fv, e_serr, e_aerr, e_stale;
  logic [7:0] p_an;
  logic [6:0] p_seg;
  logic p_dp;
  int run, since, cap_i;
  bit held, cap_p, aerr_p, pub_p;
  logic [3:0] cap_code;
  logic cap_dp;

  int ncyc = 0, d_frames = 0, d_aerr = 0, d_serr = 0, last_fv = 0, stale_rise = 0;
  bit stale_q = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", nm, act, exp, ncyc);
    end
  endtask

  function automatic logic [3:0] dec(input logic [6:0] s);
    for (int i = 0; i < 12; i++) if (s == PAT[i]) return 4'(i);
    return 4'hE;
  endfunction

  function automatic logic [7:0] strobe(input int pos);
    logic [7:0] a;
    a = 8'hFF;
    a[pos] = 1'b0;
    return a;
  endfunction

  task automatic model_edge();
    int nlow, idx, v;
    if (reset) begin
      for (int i = 0; i < ND; i++) begin m_code[i] = 4'h0; m_dp[i] = 1'b0; end
      m_mask = '0; e_digits = '0; e_dps = '0; e_value = 7'd0;
      e_vv = 0; e_fv = 0; e_serr = 0; e_aerr = 0; e_stale = 0;
      p_an = 8'hFF; p_seg = 7'h7F; p_dp = 1'b1;
      run = 1; since = 0; held = 0; cap_p = 0; aerr_p = 0; pub_p = 0;
      return;
    end
    e_fv = 0; e_serr = 0;
    since++;
    if (pub_p) begin
      for (int i = 0; i < ND; i++) begin e_digits[4*i +: 4] = m_code[i]; e_dps[i] = m_dp[i]; end
      if (m_code[0] <= 9 && m_code[1] <= 9) begin
        v = int'(m_code[1]) * 10 + int'(m_code[0]);
        e_value = 7'(v); e_vv = 1;
      end else begin
        e_value = 7'd0; e_vv = 0;
      end
      e_fv = 1; m_mask = '0; since = 0;
    end
    e_stale = (since >= (1 << TW));
    if (cap_p) begin
      m_code[cap_i] = cap_code; m_dp[cap_i] = cap_dp; m_mask[cap_i] = 1'b1;
      e_serr = (cap_code == 4'hE);
    end
    e_aerr = aerr_p;
    pub_p = &m_mask;
    // pin sample of this edge; its consequences show after the next edge
    nlow = $countones(~an);
    idx = 0;
    for (int i = 0; i < 8; i++) if (!an[i]) idx = i;
    if (an != p_an || seg != p_seg) held = 0;
    run = ({an, seg, dp} == {p_an, p_seg, p_dp}) ? run + 1 : 1;
    aerr_p = (nlow >= 2) && (an != p_an);
    cap_p = 0;
    if (!held && run == ST && nlow == 1 && idx < ND) begin
      cap_p = 1; cap_i = idx; cap_code = dec(seg); cap_dp = ~dp; held = 1;
    end
    p_an = an; p_seg = seg; p_dp = dp;
  endtask

  task automatic cyc(input logic [7:0] a, input logic [6:0] s, input logic d);
    an = a; seg = s; dp = d;
    @(posedge clock);
    model_edge();
    @(negedge clock);
    #1;
  endtask

  task automatic dwell(input int pos, input logic [6:0] s, input logic d, input int n);
    for (int k = 0; k < n; k++) cyc(strobe(pos), s, d);
  endtask

  task automatic scan(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                      input logic [6:0] s3, input int n);
    dwell(0, s0, 1'b1, n);
    dwell(1, s1, 1'b1, n);
    dwell(2, s2, 1'b1, n);
    dwell(3, s3, 1'b1, n);
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      ncyc++;
      chk("digits", 32'(digits), 32'(e_digits));
      chk("dps", 32'(dps), 32'(e_dps));
      chk("value", 32'(value), 32'(e_value));
      chk("value_valid", 32'(value_valid), 32'(e_vv));
      chk("frame_valid", 32'(frame_valid), 32'(e_fv));
      chk("seg_err", 32'(seg_err), 32'(e_serr));
      chk("an_err", 32'(an_err), 32'(e_aerr));
      chk("stale", 32'(stale), 32'(e_stale));
      if (frame_valid === 1'b1) begin d_frames++; last_fv = ncyc; end
      if (an_err === 1'b1) d_aerr++;
      if (seg_err === 1'b1) d_serr++;
      if (stale === 1'b1 && !stale_q) stale_rise = ncyc;
      stale_q = (stale === 1'b1);
    end
  end

  initial begin
    int f0, a0, s0;
    reset = 1'b1;
    cyc(8'hFF, 7'h7F, 1'b1);
    chk_en = 1'b1;
    cyc(8'hFF, 7'h7F, 1'b1);
    cyc(8'hFF, 7'h7F, 1'b1);
    chk("rst_digits", 32'(digits), 32'h0);
    chk("rst_value", 32'(value), 32'h0);
    chk("rst_frame_valid", 32'(frame_valid), 32'h0);
    chk("rst_stale", 32'(stale), 32'h0);
    reset = 1'b0;

    // two full scans of 47 with dashes above it
    f0 = d_frames;
    repeat (2) scan(PAT[7], PAT[4], PAT[10], PAT[10], 1000);
    chk("s1_frames", 32'(d_frames - f0), 32'd2);
    chk("s1_digits", 32'(digits), 32'hAA47);
    chk("s1_model_digits", 32'(e_digits), 32'hAA47);
    chk("s1_value", 32'(value), 32'd47);
    chk("s1_model_value", 32'(e_value), 32'd47);
    chk("s1_value_valid", 32'(value_valid), 32'd1);
    chk("s1_dps", 32'(dps), 32'd0);

    // digit3 dwell one short of SETTLE must not capture; earlier slots are kept
    f0 = d_frames;
    dwell(0, PAT[1], 1'b1, 10);
    dwell(1, PAT[2], 1'b1, 10);
    dwell(2, PAT[3], 1'b1, 10);
    dwell(3, PAT[4], 1'b1, ST - 1);
    dwell(0, PAT[1], 1'b1, 10);
    chk("s2_no_frame", 32'(d_frames - f0), 32'd0);
    dwell(3, PAT[4], 1'b1, 10);
    chk("s2_frames", 32'(d_frames - f0), 32'd1);
    chk("s2_digits", 32'(digits), 32'h4321);

    // two anodes low mid-scan
    f0 = d_frames; a0 = d_aerr;
    dwell(0, PAT[5], 1'b1, 10);
    dwell(1, PAT[6], 1'b1, 10);
    repeat (5) cyc(8'b11111100, PAT[5], 1'b1);
    chk("s3_an_err_pulses", 32'(d_aerr - a0), 32'd1);
    chk("s3_no_frame", 32'(d_frames - f0), 32'd0);
    dwell(2, PAT[8], 1'b1, 10);
    dwell(3, PAT[9], 1'b1, 10);
    chk("s3_frames", 32'(d_frames - f0), 32'd1);
    chk("s3_digits", 32'(digits), 32'h9865);

    // undecodable pattern on digit1, with digit0's dp lit
    s0 = d_serr;
    dwell(0, PAT[3], 1'b0, 10);
    dwell(1, 7'b0101010, 1'b1, 10);
    dwell(2, PAT[10], 1'b1, 10);
    dwell(3, PAT[10], 1'b1, 10);
    chk("s4_seg_err_pulses", 32'(d_serr - s0), 32'd1);
    chk("s4_digits", 32'(digits), 32'hAAE3);
    chk("s4_value", 32'(value), 32'd0);
    chk("s4_value_valid", 32'(value_valid), 32'd0);
    chk("s4_dps", 32'(dps), 32'h1);

    // 99 then 00, with a one-cycle seg glitch during digit0
    scan(PAT[9], PAT[9], PAT[11], PAT[11], 10);
    chk("s5_value99", 32'(value), 32'd99);
    chk("s5_model_value99", 32'(e_value), 32'd99);
    f0 = d_frames;
    dwell(0, PAT[0], 1'b1, 8);
    cyc(strobe(0), PAT[8], 1'b1);
    dwell(0, PAT[0], 1'b1, 8);
    dwell(1, PAT[0], 1'b1, 10);
    dwell(2, PAT[11], 1'b1, 10);
    dwell(3, PAT[11], 1'b1, 10);
    chk("s5_frames", 32'(d_frames - f0), 32'd1);
    chk("s5_value0", 32'(value), 32'd0);
    chk("s5_value_valid", 32'(value_valid), 32'd1);
    chk("s5_digits", 32'(digits), 32'hBB00);

    // blanked bus long enough to go stale
    repeat (300) cyc(8'hFF, 7'h7F, 1'b1);
    chk("s6_stale", 32'(stale), 32'd1);
    chk("s6_stale_latency", 32'(stale_rise - last_fv), 32'd256);

    // reset mid-scan discards the partial frame
    f0 = d_frames;
    dwell(0, PAT[1], 1'b1, 10);
    dwell(1, PAT[2], 1'b1, 10);
    reset = 1'b1;
    cyc(strobe(2), PAT[3], 1'b1);
    reset = 1'b0;
    chk("s7_rst_digits", 32'(digits), 32'h0);
    chk("s7_rst_value", 32'(value), 32'h0);
    chk("s7_rst_stale", 32'(stale), 32'h0);
    dwell(2, PAT[3], 1'b1, 10);
    dwell(3, PAT[4], 1'b1, 10);
    chk("s7_no_frame", 32'(d_frames - f0), 32'd0);
    scan(PAT[1], PAT[2], PAT[3], PAT[4], 10);
    chk("s7_frames", 32'(d_frames - f0), 32'd1);
    chk("s7_digits", 32'(digits), 32'h4321);

    // random dwells: valid strobes, blanking, out-of-range, multi-low, bad patterns, glitches
    for (int n = 0; n < 300; n++) begin
      int pick, len, i, j;
      logic [7:0] a;
      logic [6:0] s;
      logic d;
      pick = $urandom_range(0, 9);
      a = 8'hFF;
      if (pick == 4) a = 8'hFF;
      else if (pick == 5) a[$urandom_range(ND, 7)] = 1'b0;
      else if (pick == 6) begin
        i = $urandom_range(0, 7);
        j = (i + 1 + $urandom_range(0, 6)) % 8;
        a[i] = 1'b0; a[j] = 1'b0;
      end else a[$urandom_range(0, ND - 1)] = 1'b0;
      if ($urandom_range(0, 4) == 0) s = 7'($urandom);
      else s = PAT[$urandom_range(0, 11)];
      d = 1'($urandom);
      len = $urandom_range(1, 12);
      for (int k = 0; k < len; k++) begin
        if (k == len / 2 && len >= 6 && $urandom_range(0, 3) == 0)
          cyc(a, PAT[$urandom_range(0, 11)], d);
        else
          cyc(a, s, d);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
